// File: rtl/shift_offset_ctrl.sv
// Front-end sequencer for the constant-shift barrel-shifter chain: tags each
// AXI4-Stream beat with its packed-stream byte offset and tracks packet sizes.
module shift_offset_ctrl #(
   parameter int unsigned WIDTH        = 512,
   parameter int unsigned BYTES        = WIDTH / 8,
   parameter int unsigned OFFSET_WIDTH = $clog2(BYTES) + 1,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [OFFSET_WIDTH-2:0]   cfg_base_offset,
   input  logic [WIDTH-1:0]          s_tdata,
   input  logic [BYTES-1:0]          s_tkeep,
   input  logic                      s_tlast,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   output logic [WIDTH-1:0]          m_tdata,
   output logic [BYTES-1:0]          m_tkeep,
   output logic                      m_tlast,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [OFFSET_WIDTH-1:0]   m_offset,
   output logic                      m_wrap,
   output logic [CNT_WIDTH-1:0]      pkt_bytes,
   output logic                      pkt_done,
   output logic                      err_keep
);

   typedef enum logic {
      SOP    = 1'b0,
      IN_PKT = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [OFFSET_WIDTH-2:0] acc;
   logic [CNT_WIDTH-1:0]    cnt;

   logic                    accept_c;
   logic [OFFSET_WIDTH-1:0] n_c;
   logic [BYTES-1:0]        keep_inc_c;
   logic                    keep_ok_c;
   logic [OFFSET_WIDTH-2:0] beat_off_c;
   logic [OFFSET_WIDTH-1:0] off_sum_c;
   logic [CNT_WIDTH-1:0]    cnt_base_c;
   logic [CNT_WIDTH:0]      cnt_sum_wide_c;
   logic [CNT_WIDTH-1:0]    cnt_sum_c;

   // Skid-free single stage: take a beat whenever the output slot is free or draining.
   assign s_tready = aresetn && (!m_tvalid || m_tready);
   assign accept_c = s_tvalid && s_tready;

   // Byte count of the beat.
   always_comb begin
      n_c = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         n_c = n_c + OFFSET_WIDTH'(s_tkeep[i]);
      end
   end

   // A low-aligned contiguous mask has no bit set above the carry out of +1.
   assign keep_inc_c = s_tkeep + BYTES'(1);
   assign keep_ok_c  = ((keep_inc_c & s_tkeep) == '0);

   assign beat_off_c = (state == SOP) ? cfg_base_offset : acc;
   assign off_sum_c  = {1'b0, beat_off_c} + n_c;

   assign cnt_base_c     = (state == SOP) ? '0 : cnt;
   assign cnt_sum_wide_c = {1'b0, cnt_base_c} + (CNT_WIDTH + 1)'(n_c);
   assign cnt_sum_c      = cnt_sum_wide_c[CNT_WIDTH] ? '1 : cnt_sum_wide_c[CNT_WIDTH-1:0];

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= SOP;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SOP:     if (accept_c && !s_tlast) state_nxt = IN_PKT;
         IN_PKT:  if (accept_c && s_tlast)  state_nxt = SOP;
         default: state_nxt = SOP;
      endcase
   end

   // Output stage, offset accumulator and packet counter.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         m_tdata   <= '0;
         m_tkeep   <= '0;
         m_tlast   <= 1'b0;
         m_tvalid  <= 1'b0;
         m_offset  <= '0;
         m_wrap    <= 1'b0;
         pkt_bytes <= '0;
         pkt_done  <= 1'b0;
         err_keep  <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
      end else begin
         pkt_done <= 1'b0;
         if (accept_c) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
            m_offset <= {1'b0, beat_off_c};
            m_wrap   <= off_sum_c[OFFSET_WIDTH-1];
            acc      <= off_sum_c[OFFSET_WIDTH-2:0];
            if (s_tlast) begin
               pkt_bytes <= cnt_sum_c;
               pkt_done  <= 1'b1;
               cnt       <= '0;
            end else begin
               cnt <= cnt_sum_c;
            end
            if (!keep_ok_c) begin
               err_keep <= 1'b1;
            end
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_offset_ctrl.sv
// Directed bench for shift_offset_ctrl: stimulus pushes expected beats and
// packet sizes into queues, a negedge monitor pops and compares.
module tb_shift_offset_ctrl;

   localparam int unsigned WIDTH = 512;
   localparam int unsigned BYTES = 64;
   localparam int unsigned OW    = 7;
   localparam int unsigned CW    = 32;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [OW-2:0]     cfg_base_offset;
   logic [WIDTH-1:0]  s_tdata;
   logic [BYTES-1:0]  s_tkeep;
   logic              s_tlast;
   logic              s_tvalid;
   logic              s_tready;
   logic [WIDTH-1:0]  m_tdata;
   logic [BYTES-1:0]  m_tkeep;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready;
   logic [OW-1:0]     m_offset;
   logic              m_wrap;
   logic [CW-1:0]     pkt_bytes;
   logic              pkt_done;
   logic              err_keep;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [BYTES-1:0] keep;
      logic             last;
      logic [OW-1:0]    off;
      logic             wrap;
   } beat_t;

   beat_t         exp_q[$];
   logic [CW-1:0] pkt_q[$];
   int            total = 0;
   int            bad   = 0;

   shift_offset_ctrl dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .cfg_base_offset (cfg_base_offset),
      .s_tdata         (s_tdata),
      .s_tkeep         (s_tkeep),
      .s_tlast         (s_tlast),
      .s_tvalid        (s_tvalid),
      .s_tready        (s_tready),
      .m_tdata         (m_tdata),
      .m_tkeep         (m_tkeep),
      .m_tlast         (m_tlast),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_offset        (m_offset),
      .m_wrap          (m_wrap),
      .pkt_bytes       (pkt_bytes),
      .pkt_done        (pkt_done),
      .err_keep        (err_keep)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [BYTES-1:0] mk_keep(input int n);
      logic [BYTES-1:0] k;
      k = '0;
      for (int i = 0; i < n; i++) k[i] = 1'b1;
      return k;
   endfunction

   function automatic logic [WIDTH-1:0] rand_data();
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Scoreboard monitor: output beats on handshake, packet sizes on pkt_done.
   always @(negedge aclk) begin
      if (aresetn && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_beat: got offset %0h with no expected beat", m_offset);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("m_tdata",  m_tdata,  e.data);
            chk("m_tkeep",  m_tkeep,  e.keep);
            chk("m_tlast",  m_tlast,  e.last);
            chk("m_offset", m_offset, e.off);
            chk("m_wrap",   m_wrap,   e.wrap);
         end
      end
      if (aresetn && pkt_done) begin
         if (pkt_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_pkt_done: got pkt_bytes %0d with none expected", pkt_bytes);
         end else begin
            chk("pkt_bytes", pkt_bytes, pkt_q.pop_front());
         end
      end
   end

   task automatic send(input logic [BYTES-1:0] keep, input logic last,
                       input logic [OW-1:0] eoff, input logic ewrap);
      beat_t b;
      bit    taken;
      int    k;
      b.data = rand_data();
      b.keep = keep;
      b.last = last;
      b.off  = eoff;
      b.wrap = ewrap;
      exp_q.push_back(b);
      s_tdata  = b.data;
      s_tkeep  = keep;
      s_tlast  = last;
      s_tvalid = 1'b1;
      k        = 0;
      do begin
         @(negedge aclk);
         taken = s_tready;
         @(posedge aclk);
         #1;
         k++;
      end while (!taken && k < 50);
      if (!taken) chk("accept_timeout", 0, 1);
      s_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_m_tvalid"},  m_tvalid,  0);
      chk({tag, "_m_offset"},  m_offset,  0);
      chk({tag, "_m_wrap"},    m_wrap,    0);
      chk({tag, "_m_tlast"},   m_tlast,   0);
      chk({tag, "_pkt_done"},  pkt_done,  0);
      chk({tag, "_pkt_bytes"}, pkt_bytes, 0);
      chk({tag, "_err_keep"},  err_keep,  0);
      chk({tag, "_m_tdata"},   m_tdata,   0);
      chk({tag, "_m_tkeep"},   m_tkeep,   0);
      chk({tag, "_s_tready"},  s_tready,  0);
   endtask

   initial begin
      logic [WIDTH-1:0] snap_data;
      logic [OW-1:0]    snap_off;
      int               k;

      aresetn         = 1'b0;
      cfg_base_offset = '0;
      s_tdata         = '0;
      s_tkeep         = '0;
      s_tlast         = 1'b0;
      s_tvalid        = 1'b0;
      m_tready        = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_reset_vals("rst");
      @(posedge aclk);
      #1 aresetn = 1'b1;
      idle(1);

      // Three full beats from base 0: every beat fills a whole word.
      cfg_base_offset = 6'd0;
      send(mk_keep(64), 1'b0, 7'd0, 1'b1);
      send(mk_keep(64), 1'b0, 7'd0, 1'b1);
      pkt_q.push_back(32'd192);
      send(mk_keep(64), 1'b1, 7'd0, 1'b1);
      idle(2);

      // Single beat from base 60, then a new packet picks up the new base.
      cfg_base_offset = 6'd60;
      pkt_q.push_back(32'd8);
      send(mk_keep(8), 1'b1, 7'd60, 1'b1);
      cfg_base_offset = 6'd5;
      pkt_q.push_back(32'd1);
      send(mk_keep(1), 1'b1, 7'd5, 1'b0);
      idle(2);

      // Running offset 0,10,30 then wrap to 6; empty tlast beat exposes acc.
      cfg_base_offset = 6'd0;
      send(mk_keep(10), 1'b0, 7'd0, 1'b0);
      send(mk_keep(20), 1'b0, 7'd10, 1'b0);
      send(mk_keep(40), 1'b0, 7'd30, 1'b1);
      pkt_q.push_back(32'd70);
      send(mk_keep(0), 1'b1, 7'd6, 1'b0);
      idle(3);

      // Backpressure: one beat held for five cycles, then the stream resumes.
      m_tready = 1'b0;
      send(mk_keep(4), 1'b0, 7'd0, 1'b0);
      snap_data = m_tdata;
      snap_off  = m_offset;
      s_tdata   = rand_data();
      s_tkeep   = mk_keep(4);
      s_tlast   = 1'b0;
      s_tvalid  = 1'b1;
      repeat (5) begin
         @(negedge aclk);
         chk("stall_s_tready", s_tready, 0);
         chk("stall_m_tvalid", m_tvalid, 1);
         chk("stall_m_tdata",  m_tdata,  snap_data);
         chk("stall_m_offset", m_offset, snap_off);
      end
      @(posedge aclk);
      #1 m_tready = 1'b1;
      send(mk_keep(4), 1'b0, 7'd4, 1'b0);
      pkt_q.push_back(32'd12);
      send(mk_keep(4), 1'b1, 7'd8, 1'b0);
      idle(3);

      // Malformed keep: flagged, sticky, beat still counted as two bytes.
      chk("err_keep_clean", err_keep, 0);
      pkt_q.push_back(32'd2);
      send(64'h5, 1'b1, 7'd0, 1'b0);
      idle(2);
      chk("err_keep_set", err_keep, 1);
      pkt_q.push_back(32'd1);
      send(mk_keep(1), 1'b1, 7'd0, 1'b0);
      idle(3);
      chk("err_keep_sticky", err_keep, 1);

      // Reset in the middle of a packet discards it.
      cfg_base_offset = 6'd7;
      send(mk_keep(16), 1'b0, 7'd7, 1'b0);
      send(mk_keep(16), 1'b0, 7'd23, 1'b0);
      @(negedge aclk);
      #1 aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      check_reset_vals("midrst");
      @(posedge aclk);
      #1 aresetn = 1'b1;
      cfg_base_offset = 6'd3;
      send(mk_keep(16), 1'b0, 7'd3, 1'b0);
      pkt_q.push_back(32'd32);
      send(mk_keep(16), 1'b1, 7'd19, 1'b0);

      k = 0;
      while ((exp_q.size() != 0 || pkt_q.size() != 0) && k < 100) begin
         @(posedge aclk);
         k++;
      end
      idle(2);
      chk("exp_beats_left", exp_q.size(), 0);
      chk("exp_pkts_left",  pkt_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_offset_ctrl.md
Name: shift_offset_ctrl

Overview:
- Sequencer placed directly in front of the constant-shift barrel-shifter chain in the stream compaction path.
- Accepts an AXI4-Stream, computes the running byte offset of each beat within the packed output stream, and forwards each beat with its shift offset through one registered stage.
- Also reports per-packet byte counts and flags malformed keep masks, so downstream merge logic can concatenate beats without bubbles.

Parameters:
- WIDTH, 512, data width in bits; multiple of 8, BYTES a power of two.
- BYTES, WIDTH/8, bytes per beat.
- OFFSET_WIDTH, $clog2(BYTES)+1, width of the offset fed to the shifter chain.
- CNT_WIDTH, 32, width of the per-packet byte counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- cfg_base_offset  in  OFFSET_WIDTH-1  starting offset, sampled on the first beat of each packet.
- s_tdata  in  WIDTH  input data.
- s_tkeep  in  BYTES  input byte enables.
- s_tlast  in  1  input end of packet.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  WIDTH  registered copy of s_tdata.
- m_tkeep  out  BYTES  registered copy of s_tkeep.
- m_tlast  out  1  registered copy of s_tlast.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_offset  out  OFFSET_WIDTH  shift offset for this beat; MSB always 0.
- m_wrap  out  1  beat crosses a BYTES boundary of the packed stream.
- pkt_bytes  out  CNT_WIDTH  byte count of the last completed packet.
- pkt_done  out  1  one-cycle pulse when pkt_bytes updates.
- err_keep  out  1  sticky error flag for a non-contiguous tkeep.

Behaviour:
- Handshake:
  - s_tready = !m_tvalid || m_tready (combinational).
  - A beat is accepted when s_tvalid && s_tready.
  - Accept loads all m_* registers and sets m_tvalid=1.
  - m_tvalid clears when m_tready=1 and there is no accept in the same cycle.
  - Latency is 1 cycle. Full throughput: one beat per cycle while m_tready=1.
  - m_* outputs hold stable while m_tvalid && !m_tready.
- Byte count: n = popcount(s_tkeep), range 0..BYTES, width $clog2(BYTES)+1.
- State machine, 2 states:
  - SOP (reset state) -> IN_PKT on an accepted beat with s_tlast=0.
  - IN_PKT -> SOP on an accepted beat with s_tlast=1.
  - An accepted single-beat packet (s_tlast=1 in SOP) stays in SOP.
- Offset register acc (OFFSET_WIDTH-1 bits):
  - Beat offset = cfg_base_offset when the state is SOP, otherwise acc.
  - On accept: sum = beat offset + n. m_offset <= beat offset. m_wrap <= (sum >= BYTES). acc <= sum mod BYTES.
  - Wrap-around: offset 60 plus n=8 with BYTES=64 gives acc=4 and m_wrap=1.
  - A sum exactly equal to BYTES gives acc=0 and m_wrap=1.
  - n=0 beats are legal: offset unchanged, m_wrap=0.
- Packet counter cnt:
  - On accept: cnt <= (SOP ? 0 : cnt) + n, saturating at 2^CNT_WIDTH-1.
  - On an accepted tlast beat: pkt_bytes <= that same sum, pkt_done=1 for exactly one cycle, cnt <= 0.
- Keep check:
  - tkeep must be of the form 0..01..1 (low-aligned contiguous).
  - Otherwise, on accept, err_keep <= 1 and stays set until reset.
  - The beat is still forwarded using popcount.
- Reset (aresetn=0 at a clock edge):
  - m_tvalid=0, m_offset=0, m_wrap=0, m_tlast=0, pkt_done=0, pkt_bytes=0, err_keep=0, acc=0, cnt=0, state=SOP.
  - m_tdata and m_tkeep are cleared to 0.
  - s_tready is 0 during reset.
  - Reset mid-packet discards the partial packet; the next beat after reset is treated as SOP.

Test Plan:
- BYTES=64, cfg_base_offset=0, 3-beat packet, tkeep all ones, m_tready=1 -> m_offset 0,0,0; m_wrap 1,1,1; pkt_bytes=192; pkt_done pulse one cycle after the last accept.
- cfg_base_offset=60, single beat n=8 with tlast -> m_offset=60, m_wrap=1, pkt_bytes=8; the next packet starts from the new cfg_base_offset.
- Beats with n=10,20,40 -> m_offset 0,10,30; m_wrap 0,0,1; internal acc=6 after the third beat.
- m_tready held 0 for 5 cycles while s_tvalid=1 -> exactly one beat captured, s_tready=0, m_* outputs stable; on release the stream continues with no lost or duplicated beats.
- tkeep=0x...05 -> err_keep=1 and stays set; beat forwarded with n=2.
- aresetn pulsed low after beat 2 of 4 -> all outputs at reset values; a new packet then uses cfg_base_offset and cnt restarts from 0.
